// File: rtl/i2s_mask_grid.sv
// Grid-aware I2S LED stream mask: decodes each framed header, forwards only this
// module's window of the raster payload to the LED chain, then latches the row.
module i2s_mask_grid #(
    parameter int MOD_W     = 4,
    parameter int MOD_H     = 4,
    parameter int BPP       = 1,
    parameter int GRID_BITS = 4,
    parameter int ROW_BITS  = 6
) (
    input  logic                 i2s_clk,
    input  logic                 rst_n,
    input  logic                 i2s_data,
    input  logic                 i2s_ws,
    input  logic [GRID_BITS-1:0] addr_x,
    input  logic [GRID_BITS-1:0] addr_y,
    output logic [ROW_BITS-1:0]  row_num,
    output logic                 led_data,
    output logic                 led_clk,
    output logic                 led_lat,
    output logic                 led_oe,
    output logic                 frame_err,
    output logic                 addr_miss
);

    localparam int HB     = 2*GRID_BITS + ROW_BITS;
    localparam int WB     = MOD_W*BPP;
    localparam int COL_W  = GRID_BITS + $clog2(WB) + 1;
    localparam int LINE_W = GRID_BITS + $clog2(MOD_H) + 1;
    localparam int CNT_W  = $clog2(HB+1);

    localparam logic [COL_W-1:0]  WB_C   = COL_W'(WB);
    localparam logic [COL_W-1:0]  WB_M1  = COL_W'(WB-1);
    localparam logic [COL_W-1:0]  COL_1  = COL_W'(1);
    localparam logic [LINE_W-1:0] MH_C   = LINE_W'(MOD_H);
    localparam logic [LINE_W-1:0] MH_M1  = LINE_W'(MOD_H-1);
    localparam logic [LINE_W-1:0] LINE_1 = LINE_W'(1);
    localparam logic [CNT_W-1:0]  HB_M1  = CNT_W'(HB-1);
    localparam logic [CNT_W-1:0]  CNT_1  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, HDR, PAY, LATCH} state_t;

    state_t               state_q, state_n;
    logic                 ws_q, sync;
    logic [HB-2:0]        hdr_sr;
    logic [HB-1:0]        hdr_word;
    logic [CNT_W-1:0]     hdr_cnt;
    logic [GRID_BITS-1:0] hdr_nx, hdr_ny;
    logic [ROW_BITS-1:0]  hdr_row, row_q;
    logic                 hit_q;
    logic [COL_W-1:0]     col_q, col0_q, lb_m1_q;
    logic [LINE_W-1:0]    line_q, line0_q, lines_m1_q;
    logic                 clk_en_q, oe_q;
    logic                 in_win, hdr_last, en_next;

    assign sync     = i2s_ws & ~ws_q;
    assign hdr_word = {hdr_sr, i2s_data};
    assign hdr_nx   = hdr_word[HB-1 -: GRID_BITS];
    assign hdr_ny   = hdr_word[HB-1-GRID_BITS -: GRID_BITS];
    assign hdr_row  = hdr_word[ROW_BITS-1:0];

    assign in_win = hit_q
                 && (col_q  >= col0_q)  && (col_q  <= col0_q  + WB_M1)
                 && (line_q >= line0_q) && (line_q <= line0_q + MH_M1);

    // The enable is a flop, so it only moves while ~i2s_clk is low.
    assign led_clk = ~i2s_clk & clk_en_q;
    assign led_oe  = oe_q | led_lat;

    always_ff @(posedge i2s_clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: every flop uses non-blocking assignment so all registers see pre-edge values.
            state_q <= state_n;
        end
    end

    always_comb begin
        // NOTE: each output gets a default first; a missing branch assignment would infer a latch.
        state_n   = state_q;
        frame_err = 1'b0;
        addr_miss = 1'b0;
        led_lat   = 1'b0;
        hdr_last  = 1'b0;
        en_next   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync) state_n = HDR;
            end
            HDR: begin
                if (sync) begin
                    frame_err = 1'b1;
                end else if (hdr_cnt == HB_M1) begin
                    hdr_last = 1'b1;
                    state_n  = PAY;
                end
            end
            PAY: begin
                if (sync) begin
                    frame_err = 1'b1;
                    state_n   = HDR;
                end else begin
                    en_next = in_win;
                    if ((col_q == lb_m1_q) && (line_q == lines_m1_q)) state_n = LATCH;
                end
            end
            LATCH: begin
                led_lat   = hit_q;
                addr_miss = ~hit_q;
                state_n   = sync ? HDR : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i2s_clk or posedge rst_n) begin
        if (rst_n) begin
            ws_q       <= 1'b0;
            led_data   <= 1'b0;
            clk_en_q   <= 1'b0;
            oe_q       <= 1'b1;
            row_num    <= '0;
            hdr_sr     <= '0;
            hdr_cnt    <= '0;
            row_q      <= '0;
            hit_q      <= 1'b0;
            col0_q     <= '0;
            line0_q    <= '0;
            lb_m1_q    <= '0;
            lines_m1_q <= '0;
            col_q      <= '0;
            line_q     <= '0;
        end else begin
            ws_q     <= i2s_ws;
            led_data <= i2s_data;
            clk_en_q <= en_next;
            hdr_sr   <= hdr_word[HB-2:0];

            // Any sync, in any state, is the MSB of a fresh header.
            if (sync) begin
                hdr_cnt <= CNT_1;
            end else if (state_q == HDR) begin
                hdr_cnt <= hdr_cnt + CNT_1;
            end

            if (hdr_last) begin
                row_q      <= hdr_row;
                hit_q      <= (addr_x <= hdr_nx) && (addr_y <= hdr_ny);
                col0_q     <= COL_W'(addr_x) * WB_C;
                line0_q    <= LINE_W'(addr_y) * MH_C;
                lb_m1_q    <= COL_W'(hdr_nx) * WB_C + WB_M1;
                lines_m1_q <= LINE_W'(hdr_ny) * MH_C + MH_M1;
                col_q      <= '0;
                line_q     <= '0;
            end else if (state_q == PAY) begin
                if (col_q == lb_m1_q) begin
                    col_q  <= '0;
                    line_q <= line_q + LINE_1;
                end else begin
                    col_q  <= col_q + COL_1;
                end
            end

            if ((state_q == LATCH) && hit_q) begin
                row_num <= row_q;
                oe_q    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_mask_grid.sv
// Self-checking bench for i2s_mask_grid: table-driven frames plus hand-written
// abort, back-to-back, reset and geometry sequences, with a led_data scoreboard.
module tb_i2s_mask_grid;

    localparam int GB = 4;
    localparam int RB = 6;
    localparam int HB = 2*GB + RB;

    logic          i2s_clk = 1'b0;
    logic          rst_n;
    logic          i2s_data;
    logic          i2s_ws;
    logic [GB-1:0] ax1, ay1, ax2, ay2;
    logic [RB-1:0] row1, row2;
    logic          led_data1, led_clk1, led_lat1, led_oe1, frame_err1, addr_miss1;
    logic          led_data2, led_clk2, led_lat2, led_oe2, frame_err2, addr_miss2;

    always #5 i2s_clk = ~i2s_clk;

    i2s_mask_grid #(.MOD_W(4), .MOD_H(4), .BPP(1), .GRID_BITS(GB), .ROW_BITS(RB)) dut1 (
        .i2s_clk(i2s_clk), .rst_n(rst_n), .i2s_data(i2s_data), .i2s_ws(i2s_ws),
        .addr_x(ax1), .addr_y(ay1), .row_num(row1), .led_data(led_data1),
        .led_clk(led_clk1), .led_lat(led_lat1), .led_oe(led_oe1),
        .frame_err(frame_err1), .addr_miss(addr_miss1)
    );

    i2s_mask_grid #(.MOD_W(8), .MOD_H(4), .BPP(2), .GRID_BITS(GB), .ROW_BITS(RB)) dut2 (
        .i2s_clk(i2s_clk), .rst_n(rst_n), .i2s_data(i2s_data), .i2s_ws(i2s_ws),
        .addr_x(ax2), .addr_y(ay2), .row_num(row2), .led_data(led_data2),
        .led_clk(led_clk2), .led_lat(led_lat2), .led_oe(led_oe2),
        .frame_err(frame_err2), .addr_miss(addr_miss2)
    );

    int checks = 0;
    int errors = 0;
    int lat1 = 0, miss1 = 0, err1 = 0, edges1 = 0, exp_edges1 = 0;
    int lat2 = 0, edges2 = 0, exp_edges2 = 0;
    bit oe_at_lat1 = 1'b0;
    bit chk2 = 1'b0;
    bit q1[$];
    bit q2[$];

    typedef struct {
        logic [GB-1:0] ax, ay, nx, ny;
        logic [RB-1:0] row;
        bit            rnd;
        int            exp_lat;
        int            exp_miss;
        logic [RB-1:0] exp_row;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse counters sample mid-cycle, away from the active edge.
    always @(negedge i2s_clk) begin
        if (led_lat1) begin
            lat1       <= lat1 + 1;
            oe_at_lat1 <= led_oe1;
        end
        if (addr_miss1) miss1 <= miss1 + 1;
        if (frame_err1) err1  <= err1 + 1;
        if (led_lat2)   lat2  <= lat2 + 1;
    end

    always @(posedge led_clk1) begin
        edges1 <= edges1 + 1;
        if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL led_clk1 edge with no expected bit: led_data=%0b", led_data1);
        end else begin
            check("led_data1", {31'd0, led_data1}, {31'd0, q1.pop_front()});
        end
    end

    always @(posedge led_clk2) begin
        if (chk2) begin
            edges2 <= edges2 + 1;
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL led_clk2 edge with no expected bit: led_data=%0b", led_data2);
            end else begin
                check("led_data2", {31'd0, led_data2}, {31'd0, q2.pop_front()});
            end
        end
    end

    // Reference window model: raster index -> (line, column) by division.
    function automatic bit exp_en(input int k, input int nx, input int ny, input int ax,
                                  input int ay, input int wb, input int mh);
        int lb, line, col;
        lb   = (nx + 1) * wb;
        line = k / lb;
        col  = k % lb;
        if (ax > nx || ay > ny) return 1'b0;
        if (k >= lb * (ny + 1) * mh) return 1'b0;
        return (col >= ax*wb) && (col < (ax+1)*wb) && (line >= ay*mh) && (line < (ay+1)*mh);
    endfunction

    task automatic drive(input logic ws, input logic d);
        @(posedge i2s_clk);
        #1;
        i2s_ws   = ws;
        i2s_data = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [GB-1:0] nx, input logic [GB-1:0] ny,
                              input logic [RB-1:0] row, input bit rnd, input int abort_at);
        logic [HB-1:0] h;
        int npay;
        bit d;
        h = {nx, ny, row};
        for (int i = HB-1; i >= 0; i--) drive(i == HB-1, h[i]);
        npay = chk2 ? (int'(nx)+1)*16*(int'(ny)+1)*4 : (int'(nx)+1)*4*(int'(ny)+1)*4;
        for (int k = 0; k < npay; k++) begin
            if (k == abort_at) return;
            d = rnd ? 1'($urandom_range(0, 1)) : k[0];
            if (exp_en(k, int'(nx), int'(ny), int'(ax1), int'(ay1), 4, 4)) begin
                q1.push_back(d);
                exp_edges1++;
            end
            if (chk2 && exp_en(k, int'(nx), int'(ny), int'(ax2), int'(ay2), 16, 4)) begin
                q2.push_back(d);
                exp_edges2++;
            end
            drive(1'b0, d);
        end
    endtask

    task automatic apply_reset();
        rst_n    = 1'b1;
        i2s_ws   = 1'b0;
        i2s_data = 1'b0;
        repeat (3) @(posedge i2s_clk);
        #1 rst_n = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_row_num"},   {26'd0, row1},       32'd0);
        check({tag, "_led_data"},  {31'd0, led_data1},  32'd0);
        check({tag, "_led_clk"},   {31'd0, led_clk1},   32'd0);
        check({tag, "_led_lat"},   {31'd0, led_lat1},   32'd0);
        check({tag, "_led_oe"},    {31'd0, led_oe1},    32'd1);
        check({tag, "_frame_err"}, {31'd0, frame_err1}, 32'd0);
        check({tag, "_addr_miss"}, {31'd0, addr_miss1}, 32'd0);
        check({tag, "_led_oe2"},   {31'd0, led_oe2},    32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int l0, m0, e0, l2;

        vecs[0] = '{ax:4'd1,  ay:4'd0,  nx:4'd1,  ny:4'd1,  row:6'h2A, rnd:1'b0, exp_lat:1, exp_miss:0, exp_row:6'h2A};
        vecs[1] = '{ax:4'd2,  ay:4'd0,  nx:4'd1,  ny:4'd1,  row:6'h15, rnd:1'b1, exp_lat:0, exp_miss:1, exp_row:6'h2A};
        vecs[2] = '{ax:4'd0,  ay:4'd1,  nx:4'd1,  ny:4'd1,  row:6'h33, rnd:1'b1, exp_lat:1, exp_miss:0, exp_row:6'h33};
        vecs[3] = '{ax:4'd3,  ay:4'd2,  nx:4'd3,  ny:4'd2,  row:6'h07, rnd:1'b1, exp_lat:1, exp_miss:0, exp_row:6'h07};
        vecs[4] = '{ax:4'd1,  ay:4'd3,  nx:4'd3,  ny:4'd2,  row:6'h11, rnd:1'b1, exp_lat:0, exp_miss:1, exp_row:6'h07};
        vecs[5] = '{ax:4'd15, ay:4'd15, nx:4'd15, ny:4'd15, row:6'h3F, rnd:1'b1, exp_lat:1, exp_miss:0, exp_row:6'h3F};

        ax1 = '0; ay1 = '0; ax2 = '0; ay2 = '0;
        apply_reset();
        check_reset_vals("reset");

        foreach (vecs[i]) begin
            ax1 = vecs[i].ax;
            ay1 = vecs[i].ay;
            l0  = lat1;
            m0  = miss1;
            e0  = err1;
            send_frame(vecs[i].nx, vecs[i].ny, vecs[i].row, vecs[i].rnd, -1);
            drive(1'b0, 1'b0);
            check($sformatf("v%0d_lat_early", i), lat1 - l0, 32'd0);
            idle(3);
            check($sformatf("v%0d_lat", i),   lat1 - l0,  vecs[i].exp_lat);
            check($sformatf("v%0d_miss", i),  miss1 - m0, vecs[i].exp_miss);
            check($sformatf("v%0d_err", i),   err1 - e0,  32'd0);
            check($sformatf("v%0d_row", i),   {26'd0, row1}, {26'd0, vecs[i].exp_row});
            check($sformatf("v%0d_oe", i),    {31'd0, led_oe1}, 32'd0);
            check($sformatf("v%0d_edges", i), edges1, exp_edges1);
            check($sformatf("v%0d_q", i),     q1.size(), 32'd0);
            if (vecs[i].exp_lat != 0) check($sformatf("v%0d_oe_at_lat", i), {31'd0, oe_at_lat1}, 32'd1);
        end

        // Mid-payload abort: the sync bit doubles as the next header MSB.
        ax1 = 4'd1; ay1 = 4'd0;
        l0 = lat1; e0 = err1;
        send_frame(4'd1, 4'd1, 6'h3C, 1'b0, 20);
        send_frame(4'd1, 4'd1, 6'h05, 1'b1, -1);
        idle(4);
        check("abort_err",   err1 - e0, 32'd1);
        check("abort_lat",   lat1 - l0, 32'd1);
        check("abort_row",   {26'd0, row1}, 32'h05);
        check("abort_edges", edges1, exp_edges1);
        check("abort_q",     q1.size(), 32'd0);

        // Back-to-back: second sync lands on the LATCH cycle.
        l0 = lat1; e0 = err1;
        send_frame(4'd1, 4'd1, 6'h12, 1'b1, -1);
        send_frame(4'd1, 4'd1, 6'h21, 1'b1, -1);
        idle(4);
        check("b2b_lat",   lat1 - l0, 32'd2);
        check("b2b_err",   err1 - e0, 32'd0);
        check("b2b_row",   {26'd0, row1}, 32'h21);
        check("b2b_edges", edges1, exp_edges1);
        check("b2b_q",     q1.size(), 32'd0);

        // Asynchronous reset in the middle of the payload.
        l0 = lat1; e0 = err1;
        send_frame(4'd1, 4'd1, 6'h30, 1'b1, 18);
        #2 rst_n = 1'b1;
        #1 check_reset_vals("midpay");
        @(posedge i2s_clk);
        #1 rst_n = 1'b0;
        for (int k = 18; k < 64; k++) drive(1'b0, 1'($urandom_range(0, 1)));
        idle(3);
        check("rst_lat",   lat1 - l0, 32'd0);
        check("rst_err",   err1 - e0, 32'd0);
        check("rst_edges", edges1, exp_edges1);
        check("rst_row",   {26'd0, row1}, 32'd0);
        send_frame(4'd1, 4'd1, 6'h0A, 1'b1, -1);
        idle(3);
        check("rst_next_lat", lat1 - l0, 32'd1);
        check("rst_next_row", {26'd0, row1}, 32'h0A);
        check("rst_next_q",   q1.size(), 32'd0);

        // Wider geometry instance: MOD_W=8, BPP=2, single-module grid.
        apply_reset();
        ax1 = '0; ay1 = '0; ax2 = '0; ay2 = '0;
        chk2 = 1'b1;
        l2 = lat2;
        send_frame(4'd0, 4'd0, 6'h1B, 1'b1, -1);
        drive(1'b0, 1'b0);
        check("geom_lat_early", lat2 - l2, 32'd0);
        idle(3);
        check("geom_lat",    lat2 - l2, 32'd1);
        check("geom_edges",  edges2, 32'd64);
        check("geom_q",      q2.size(), 32'd0);
        check("geom_row",    {26'd0, row2}, 32'h1B);
        check("geom_oe",     {31'd0, led_oe2}, 32'd0);
        check("geom_edges1", edges1, exp_edges1);
        check("geom_q1",     q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_mask_grid.md
Name: i2s_mask_grid

Overview:
- Parametrised successor of the serial LED-stream mask.
- Watches a framed I2S-style bitstream carrying a header plus a raster payload for a grid of LED modules.
- Forwards to the local LED driver chain only the bits belonging to this module's grid position, then issues a latch pulse and the row number.
- Adds over the previous generation: configurable module geometry and bits per pixel, word-select frame sync with mid-frame abort, out-of-grid detection, glitch-free clock gating.

Parameters:
- MOD_W, 4: module width in pixels.
- MOD_H, 4: module height in lines.
- BPP, 1: bits per pixel.
- GRID_BITS, 4: width of the grid size and address fields. Grid is up to 2^GRID_BITS modules per axis.
- ROW_BITS, 6: width of the row-number field.

Ports:
- i2s_clk, in, 1: stream clock; all logic on its rising edge.
- rst_n, in, 1: asynchronous reset, active-high (asserted = 1).
- i2s_data, in, 1: serial stream, MSB first.
- i2s_ws, in, 1: frame sync; a 0→1 transition marks the header MSB.
- addr_x, in, GRID_BITS: this module's column in the grid.
- addr_y, in, GRID_BITS: this module's row in the grid.
- row_num, out, ROW_BITS: row number from the last good frame.
- led_data, out, 1: registered copy of i2s_data.
- led_clk, out, 1: gated clock, equal to ~i2s_clk & clk_en_q.
- led_lat, out, 1: one-cycle latch pulse.
- led_oe, out, 1: active-low output enable.
- frame_err, out, 1: one-cycle pulse when a frame is aborted.
- addr_miss, out, 1: one-cycle pulse when this module's address lies outside the header's grid.

Behaviour:
- Reset values: row_num=0, led_data=0, clk_en_q=0 (so led_clk=0), led_lat=0, led_oe=1, frame_err=0, addr_miss=0. State goes to IDLE.
- Reset mid-frame drops the frame silently with no latch and no error pulse.
- ws_q holds i2s_ws from the previous cycle. sync = i2s_ws & ~ws_q.
- Header: HB = 2*GRID_BITS + ROW_BITS bits, MSB first, laid out as {nx_m1, ny_m1, row}.
  - NX = nx_m1 + 1; NY = ny_m1 + 1.
- Payload geometry:
  - LB = NX*MOD_W*BPP bits per line.
  - NY*MOD_H lines in raster order, line 0 first.
  - Total payload = LB*NY*MOD_H bits.
- Counters: bit-in-line (col) and line counters, wide enough for the maximum grid. They are computed at header end and must not overflow at the maximum grid.
- FSM:
  - IDLE: wait for sync. The bit sampled on the sync cycle is header bit HB-1. Go to HDR.
  - HDR: shift HB bits. On the cycle the last header bit is sampled:
    - register nx_m1, ny_m1, row.
    - compute hit = (addr_x <= nx_m1) && (addr_y <= ny_m1).
    - compute window start col0 = addr_x*MOD_W*BPP and line window addr_y*MOD_H .. addr_y*MOD_H + MOD_H - 1.
    - clear counters and go to PAY.
  - PAY: one payload bit per cycle.
    - Enable_next = hit && col in [col0, col0 + MOD_W*BPP - 1] && line in the window.
    - clk_en_q <= enable_next on the same edge that loads led_data <= i2s_data, so data and enable align. The first led_clk rising edge falls in the middle of that data bit.
    - When the last payload bit is sampled, go to LATCH.
  - LATCH (one cycle): clk_en_q=0.
    - If hit: led_lat=1, led_oe=1, row_num <= row.
    - Else: addr_miss=1, row_num unchanged.
    - Next state is HDR if sync is seen this cycle, otherwise IDLE.
- led_oe behaviour:
  - Returns to 0 in the cycle after a latch.
  - Stays 1 from reset until the first successful latch.
  - Otherwise stays 0, including during bad frames.
- Sync in HDR or PAY is an abort: frame_err=1 for that cycle, clk_en_q <= 0, no latch, row_num unchanged. The sync bit is treated as the new header MSB, so the FSM re-enters HDR with the count restarted.
- Exactly MOD_W*BPP*MOD_H led_clk rising edges per hit frame. Zero edges on a miss or abort.
- Address change mid-frame has no effect; hit and col0 are captured at header end.
- Glitch-free clock gating:
  - clk_en_q changes only at the i2s_clk rising edge, when ~i2s_clk is low, so led_clk cannot glitch.
  - This must be a single register feeding the AND gate (or a clock-gate cell), never a combinational enable.

Test Plan:
- Good frame, defaults. Reset, then addr=(1,0); sync with header nx_m1=1, ny_m1=1, row=0x2A (bits 0001_0001_101010), then 64 payload bits at index k, payload[k]=k[0]. Expect 16 led_clk edges on payload indices 4–7, 12–15, 20–23 and 28–31, with led_data matching at each edge. Expect led_lat pulse 1 cycle after payload bit 63, row_num=0x2A, led_oe 1→0.
- Out of grid. Same frame with addr=(2,0). Expect 0 led_clk edges, addr_miss pulse, no led_lat, row_num unchanged.
- Mid-payload abort. Sync at payload bit 20. Expect frame_err pulse and clk_en low that cycle. The following complete frame with row=0x05 is processed normally with row_num=0x05.
- Back-to-back frames. Sync asserted on the LATCH cycle; the second frame is decoded with no dropped bits.
- Geometry parameters. MOD_W=8, BPP=2, nx_m1=0, ny_m1=0, addr=(0,0). Expect 64 led_clk edges and latch after 64 payload bits.
- Async reset mid-PAY. All outputs return to their reset values immediately. No latch until the next sync plus a full frame.
